// File: rtl/orc_mem_responder.sv
// ORC_R32I native-bus responder: word RAM with byte strobes, programmable wait states, console FIFO.
// Define ORC_MEM_ADDR_CHECK_EN to flag accesses above the RAM window (DEAD_BEEF read, sticky o_bus_err).

module orc_mem_responder #(
  parameter int          MEM_WORDS     = 65536,
  parameter int          WAIT_CYCLES   = 0,
  parameter logic [31:0] CONSOLE_ADDR  = 32'h1000_0000,
  parameter int          CONSOLE_DEPTH = 4,
  parameter string       INIT_FILE     = ""
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        o_console_valid,
  output logic [7:0]  o_console_data,
  input  logic        i_console_ready,
  output logic        o_bus_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(CONSOLE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    wait_cnt_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [3:0]    wstrb_r;
  logic          mem_ready_r;
  logic [31:0]   mem_rdata_r;
  logic [31:0]   ram_r [MEM_WORDS];
  logic [7:0]    fifo_r [CONSOLE_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          is_console_s;
  logic          is_write_s;
  logic          fifo_full_s;
  logic          stall_s;
  logic          oob_s;
  logic          access_s;
  logic          ram_we_s;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic          unused_ok_s;

  // Decode of the captured request and access/stall qualification
  always_comb begin
    is_console_s = (addr_r[31:2] == CONSOLE_ADDR[31:2]);
    is_write_s   = (wstrb_r != 4'b0000);
    fifo_full_s  = (count_r == CW'(CONSOLE_DEPTH));
    stall_s      = is_console_s && is_write_s && fifo_full_s;
`ifdef ORC_MEM_ADDR_CHECK_EN
    oob_s        = ((addr_r >> (AW + 2)) != 32'd0) && !is_console_s;
`else
    oob_s        = 1'b0;
`endif
    access_s     = (state_r == ST_WAIT) && (wait_cnt_r == 4'd0) && !stall_s;
    ram_we_s     = access_s && is_write_s && !is_console_s && !oob_s;
    push_s       = access_s && is_console_s && is_write_s;
    pop_s        = (count_r != CW'(0)) && i_console_ready;
    idx_s        = addr_r[AW+1:2];
    if (is_console_s) begin
      rd_word_s = {28'd0, 4'(count_r)};
    end else if (oob_s) begin
      rd_word_s = 32'hDEAD_BEEF;
    end else begin
      rd_word_s = ram_r[idx_s];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_valid) state_nxt_s = ST_WAIT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (access_s) state_nxt_s = ST_RESP;
        else          state_nxt_s = ST_WAIT;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_r <= ST_IDLE;
    else            state_r <= state_nxt_s;
  end

  // Request capture, wait countdown and registered response
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt_r  <= 4'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      wstrb_r     <= 4'd0;
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'd0;
    end else begin
      if ((state_r == ST_IDLE) && mem_valid) begin
        addr_r     <= mem_addr;
        wdata_r    <= mem_wdata;
        wstrb_r    <= mem_wstrb;
        wait_cnt_r <= 4'(WAIT_CYCLES);
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end
      mem_ready_r <= access_s;
      if (access_s) begin
        mem_rdata_r <= is_write_s ? 32'd0 : rd_word_s;
      end
    end
  end

  // RAM byte-lane write port
  always_ff @(posedge i_clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_r[b]) ram_r[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
      end
    end
  end

  // Console FIFO storage
  always_ff @(posedge i_clk) begin
    if (push_s) fifo_r[wr_ptr_r] <= wdata_r[7:0];
  end

  // Console FIFO pointers and occupancy; a push while full is already blocked by stall_s
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef ORC_MEM_ADDR_CHECK_EN
  logic bus_err_r;

  // Sticky out-of-range access flag
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              bus_err_r <= 1'b0;
    else if (access_s && oob_s)  bus_err_r <= 1'b1;
  end

  assign o_bus_err = bus_err_r;
`else
  assign o_bus_err = 1'b0;
`endif

  assign mem_ready       = mem_ready_r;
  assign mem_rdata       = mem_rdata_r;
  assign o_console_valid = (count_r != CW'(0));
  assign o_console_data  = o_console_valid ? fifo_r[rd_ptr_r] : 8'h00;
  assign unused_ok_s     = ^{mem_instr, addr_r[1:0]};

endmodule

// File: tb/tb_orc_mem_responder.sv
// Randomized self-checking bench for orc_mem_responder against a transaction-level reference model.
// Honours ORC_MEM_ADDR_CHECK_EN the same way the design does.

module tb_orc_mem_responder;

  localparam int          W     = 3;
  localparam int          DEPTH = 4;
  localparam int          WORDS = 65536;
  localparam logic [31:0] CON_A = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        o_console_valid;
  logic [7:0]  o_console_data;
  logic        i_console_ready;
  logic        o_bus_err;

  orc_mem_responder #(
    .MEM_WORDS(WORDS), .WAIT_CYCLES(W), .CONSOLE_ADDR(CON_A), .CONSOLE_DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .o_console_valid(o_console_valid), .o_console_data(o_console_data),
    .i_console_ready(i_console_ready), .o_bus_err(o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, RAM as sparse map, console as byte queue
  logic [31:0] mem_model [int];
  logic [7:0]  m_q [$];
  logic [7:0]  dut_popped [$];
  bit          m_busy = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_err = 1'b0;
  bit          rd_known = 1'b0;
  int          m_elapsed = 0;
  logic [31:0] m_addr, m_wdata, rd_exp, old_w;
  logic [3:0]  m_wstrb;
  bit          s_rst, s_valid, s_cready, s_cvalid, do_pop, push_now, is_con, is_wr, oob;
  logic [31:0] s_addr, s_wdata, con_word;
  logic [3:0]  s_wstrb;
  logic [7:0]  s_cdata, push_byte;
  int          widx;

  always @(posedge clk) begin
    s_rst = rst_n; s_valid = mem_valid; s_addr = mem_addr; s_wdata = mem_wdata;
    s_wstrb = mem_wstrb; s_cready = i_console_ready; s_cvalid = o_console_valid; s_cdata = o_console_data;
    if (!s_rst) begin
      m_busy = 1'b0; m_resp = 1'b0; m_err = 1'b0; m_q.delete();
    end else begin
      if (s_cvalid && s_cready) dut_popped.push_back(s_cdata);
      do_pop = (m_q.size() != 0) && s_cready;
      push_now = 1'b0;
      con_word = CON_A >> 2;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (m_busy) begin
        m_elapsed++;
        is_con = ((m_addr >> 2) == con_word);
        is_wr  = (m_wstrb != 4'd0);
        if (m_elapsed >= W + 1 && !(is_con && is_wr && m_q.size() >= DEPTH)) begin
          widx = int'((m_addr >> 2) % WORDS);
`ifdef ORC_MEM_ADDR_CHECK_EN
          oob = ((m_addr >> 2) >= WORDS) && !is_con;
`else
          oob = 1'b0;
`endif
          rd_known = 1'b1;
          if (is_con) begin
            if (is_wr) begin push_now = 1'b1; push_byte = m_wdata[7:0]; rd_exp = 32'd0; end
            else rd_exp = 32'(m_q.size() % 16);
          end else if (oob) begin
            rd_exp = is_wr ? 32'd0 : 32'hDEAD_BEEF;
            m_err = 1'b1;
          end else if (is_wr) begin
            old_w = mem_model.exists(widx) ? mem_model[widx] : 32'd0;
            for (int b = 0; b < 4; b++) if (m_wstrb[b]) old_w[8*b +: 8] = m_wdata[8*b +: 8];
            mem_model[widx] = old_w;
            rd_exp = 32'd0;
          end else begin
            rd_known = mem_model.exists(widx);
            rd_exp = rd_known ? mem_model[widx] : 32'd0;
          end
          m_busy = 1'b0;
          m_resp = 1'b1;
        end
      end else if (s_valid) begin
        m_busy = 1'b1; m_elapsed = 0;
        m_addr = s_addr; m_wdata = s_wdata; m_wstrb = s_wstrb;
      end
      if (do_pop) void'(m_q.pop_front());
      if (push_now) m_q.push_back(push_byte);
    end
    #1;
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_resp});
    if (m_resp && rd_known) chk("mem_rdata", mem_rdata, rd_exp);
    chk("console_valid", {31'd0, o_console_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
    if (m_q.size() != 0) chk("console_data", {24'd0, o_console_data}, {24'd0, m_q[0]});
    chk("bus_err", {31'd0, o_bus_err}, {31'd0, m_err});
  end

  bit rand_ready = 1'b0;

  // One request; returns read data and latency in cycles from mem_valid rising to mem_ready
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    mem_instr = 1'($urandom_range(0, 1));
    lat = 0; rd = 32'd0;
    forever begin
      @(negedge clk);
      lat++;
      if (rand_ready) i_console_ready = 1'($urandom_range(0, 1));
      if (mem_ready) break;
      if (lat > 200) begin
        n_chk++; n_err++;
        $display("FAIL req_timeout: no mem_ready after %0d cycles for addr %h, required <= 200", lat, a);
        break;
      end
    end
    rd = mem_rdata;
    mem_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;
  int          lat5;
  logic [31:0] pool [16];

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'd0;
    mem_wdata = 32'd0; mem_wstrb = 4'd0; i_console_ready = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_cvalid", {31'd0, o_console_valid}, 32'd0);
    chk("rst_cdata", {24'd0, o_console_data}, 32'd0);
    chk("rst_bus_err", {31'd0, o_bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    req(32'h0000_0100, 32'h1234_5678, 4'hF, rd, lat);
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_rdata_zero", rd, 32'd0);
    req(32'h0000_0100, 32'd0, 4'h0, rd, lat);
    chk("rd_latency", 32'(lat), 32'd5);
    chk("rd_word", rd, 32'h1234_5678);

    req(32'h0000_0040, 32'hAABB_CCDD, 4'hF, rd, lat);
    req(32'h0000_0040, 32'h0000_EE00, 4'b0010, rd, lat);
    req(32'h0000_0042, 32'd0, 4'h0, rd, lat);
    chk("byte_lane", rd, 32'hAABB_EEDD);

    // Console occupancy readback, then drain
    i_console_ready = 1'b0;
    req(CON_A, 32'h0000_0078, 4'h1, rd, lat);
    req(CON_A, 32'h0000_0079, 4'h1, rd, lat);
    req(CON_A, 32'd0, 4'h0, rd, lat);
    chk("console_count", rd, 32'd2);
    i_console_ready = 1'b1;
    repeat (6) @(negedge clk);
    i_console_ready = 1'b0;
    dut_popped.delete();

    // Console back-pressure: fifth byte must stall until the consumer frees a slot
    for (int i = 0; i < 4; i++) req(CON_A, 32'h41 + 32'(i), 4'hF, rd, lat);
    fork
      req(CON_A, 32'h45, 4'hF, rd, lat5);
      begin repeat (8) @(negedge clk); i_console_ready = 1'b1; end
    join
    chk("console_stall", (lat5 > 8) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 50 && dut_popped.size() < 5; i++) @(negedge clk);
    chk("console_drained", 32'(dut_popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_popped.size(); i++)
      chk("console_order", {24'd0, dut_popped[i]}, 32'h41 + 32'(i));

    // Reset in the middle of a write: no response, RAM and FIFO unaffected/emptied
    i_console_ready = 1'b0;
    req(32'h0000_0200, 32'h0BAD_F00D, 4'hF, rd, lat);
    req(CON_A, 32'h5A, 4'h1, rd, lat);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_mid_fifo", {31'd0, o_console_valid}, 32'd0);
    rst_n = 1'b1;
    req(32'h0000_0200, 32'd0, 4'h0, rd, lat);
    chk("rst_mid_ram", rd, 32'h0BAD_F00D);

`ifdef ORC_MEM_ADDR_CHECK_EN
    req(32'h0010_0000, 32'd0, 4'h0, rd, lat);
    chk("oob_read", rd, 32'hDEAD_BEEF);
    chk("oob_err", {31'd0, o_bus_err}, 32'd1);
`else
    req(32'h0004_0100, 32'hCAFE_0001, 4'hF, rd, lat);
    req(32'h0000_0100, 32'd0, 4'h0, rd, lat);
    chk("alias_read", rd, 32'hCAFE_0001);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) begin
      pool[i] = 32'h0000_2000 + 32'(4 * i);
      req(pool[i], $urandom, 4'hF, rd, lat);
    end
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 15)];
      if (kind == 6 || kind == 7) a = CON_A;
      else if (kind == 8) a = a + 32'h0004_0000 * 32'($urandom_range(1, 3));
      else if (kind == 9) a = a + 32'($urandom_range(0, 3));
      req(a, $urandom, 4'($urandom_range(0, 15)), rd, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_ready = 1'b0;
    i_console_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1000000 time units, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
